// File: rtl/locals_frame_unit.sv
// locals_frame_unit: typed local-variable store with a call-frame stack for the wasm CPU.
// Locals live in a sync-read RAM of {type,data}; each pushed frame is zero-filled one entry per cycle.
module locals_frame_unit #(
   parameter bit          USE_64B  = 1'b1,
   parameter int unsigned LOCAL_AW = 6,
   parameter int unsigned FRAME_AW = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                op_valid,
   output logic                op_ready,
   input  logic [2:0]          op,
   input  logic [LOCAL_AW-1:0] index,
   input  logic [LOCAL_AW:0]   frame_size,
   input  logic [63:0]         wdata,
   input  logic [1:0]          wtype,
   output logic [63:0]         rdata,
   output logic [1:0]          rtype,
   output logic                rvalid,
   output logic [FRAME_AW:0]   frame_level,
   output logic [3:0]          trap
);

   localparam int unsigned AW1    = LOCAL_AW + 1;
   localparam int unsigned AW2    = LOCAL_AW + 2;
   localparam int unsigned LW     = FRAME_AW + 1;
   localparam int unsigned EW     = 66;
   localparam int unsigned DEPTH  = 2 ** LOCAL_AW;
   localparam int unsigned FDEPTH = 2 ** FRAME_AW;

   localparam logic [2:0] OP_GET  = 3'd0;
   localparam logic [2:0] OP_SET  = 3'd1;
   localparam logic [2:0] OP_TEE  = 3'd2;
   localparam logic [2:0] OP_PUSH = 3'd3;
   localparam logic [2:0] OP_POP  = 3'd4;

   localparam logic [1:0] TY_I32 = 2'd0;
   localparam logic [1:0] TY_I64 = 2'd1;
   localparam logic [1:0] TY_F64 = 2'd3;

   localparam logic [3:0] TRAP_NONE            = 4'd0;
   localparam logic [3:0] TRAP_BAD_OP          = 4'd1;
   localparam logic [3:0] TRAP_NO_64B          = 4'd2;
   localparam logic [3:0] TRAP_BAD_INDEX       = 4'd3;
   localparam logic [3:0] TRAP_FRAME_OVERFLOW  = 4'd4;
   localparam logic [3:0] TRAP_FRAME_UNDERFLOW = 4'd5;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_INIT, S_HALT} state_t;

   state_t           state_q, state_d;
   logic [AW1-1:0]   base_q, base_d, size_q, size_d, fill_q, fill_d;
   logic [LW-1:0]    level_q, level_d;
   logic [3:0]       trap_q, trap_d;
   logic [63:0]      rdata_q, rdata_d;
   logic [1:0]       rtype_q, rtype_d;
   logic             rvalid_q, rvalid_d;
   logic             ready_q, ready_d;

   logic [EW-1:0]    mem [DEPTH];
   logic [EW-1:0]    ram_q;
   logic [AW1-1:0]   fs_base [FDEPTH];
   logic [AW1-1:0]   fs_size [FDEPTH];

   logic                accept, is_wr, is_acc, is_64;
   logic [AW2-1:0]      end_sum;
   logic [3:0]          trap_code;
   logic [AW1-1:0]      acc_addr;
   logic [63:0]         wdata_st;
   logic [FRAME_AW-1:0] push_idx, pop_idx;
   logic                mem_we, mem_re, fs_we;
   logic [LOCAL_AW-1:0] mem_waddr, mem_raddr;
   logic [EW-1:0]       mem_wentry;

   assign accept   = op_valid & ready_q;
   assign is_wr    = (op == OP_SET) || (op == OP_TEE);
   assign is_acc   = is_wr || (op == OP_GET);
   assign is_64    = (wtype == TY_I64) || (wtype == TY_F64);
   assign acc_addr = base_q + AW1'(index);
   assign end_sum  = AW2'(base_q) + AW2'(size_q) + AW2'(frame_size);
   assign wdata_st = USE_64B ? wdata : {32'd0, wdata[31:0]};
   assign push_idx = FRAME_AW'(level_q);
   assign pop_idx  = FRAME_AW'(level_q - LW'(1));

   // Trap classification of the presented op, highest priority first
   always_comb begin
      trap_code = TRAP_NONE;
      if (op > OP_POP)
         trap_code = TRAP_BAD_OP;
      else if (is_wr && !USE_64B && is_64)
         trap_code = TRAP_NO_64B;
      else if (is_acc && (AW1'(index) >= size_q))
         trap_code = TRAP_BAD_INDEX;
      else if ((op == OP_PUSH) && ((level_q == LW'(FDEPTH)) || (end_sum > AW2'(DEPTH))))
         trap_code = TRAP_FRAME_OVERFLOW;
      else if ((op == OP_POP) && (level_q == '0))
         trap_code = TRAP_FRAME_UNDERFLOW;
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      size_d     = size_q;
      level_d    = level_q;
      fill_d     = fill_q;
      trap_d     = trap_q;
      rdata_d    = rdata_q;
      rtype_d    = rtype_q;
      rvalid_d   = 1'b0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      fs_we      = 1'b0;
      mem_waddr  = LOCAL_AW'(acc_addr);
      mem_raddr  = LOCAL_AW'(acc_addr);
      mem_wentry = {wtype, wdata_st};
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (trap_code != TRAP_NONE) begin
                  trap_d  = trap_code;
                  state_d = S_HALT;
               end else begin
                  unique case (op)
                     OP_GET: begin
                        mem_re  = 1'b1;
                        state_d = S_READ;
                     end
                     OP_SET: mem_we = 1'b1;
                     OP_TEE: begin
                        mem_we   = 1'b1;
                        rvalid_d = 1'b1;
                        rdata_d  = wdata;
                        rtype_d  = wtype;
                     end
                     OP_PUSH: begin
                        fs_we   = 1'b1;
                        base_d  = base_q + size_q;
                        size_d  = frame_size;
                        level_d = level_q + LW'(1);
                        fill_d  = '0;
                        if (frame_size != '0) state_d = S_INIT;
                     end
                     default: begin
                        base_d  = fs_base[pop_idx];
                        size_d  = fs_size[pop_idx];
                        level_d = level_q - LW'(1);
                     end
                  endcase
               end
            end
         end
         S_READ: begin
            rvalid_d = 1'b1;
            rdata_d  = ram_q[63:0];
            rtype_d  = ram_q[65:64];
            state_d  = S_IDLE;
         end
         S_INIT: begin
            mem_we     = 1'b1;
            mem_waddr  = LOCAL_AW'(base_q + fill_q);
            mem_wentry = {TY_I32, 64'd0};
            fill_d     = fill_q + AW1'(1);
            if (fill_q == size_q - AW1'(1)) state_d = S_IDLE;
         end
         default: ;
      endcase
      ready_d = (state_d == S_IDLE) && (trap_d == TRAP_NONE);
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         base_q   <= '0;
         size_q   <= '0;
         level_q  <= '0;
         fill_q   <= '0;
         trap_q   <= TRAP_NONE;
         rdata_q  <= '0;
         rtype_q  <= TY_I32;
         rvalid_q <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         base_q   <= base_d;
         size_q   <= size_d;
         level_q  <= level_d;
         fill_q   <= fill_d;
         trap_q   <= trap_d;
         rdata_q  <= rdata_d;
         rtype_q  <= rtype_d;
         rvalid_q <= rvalid_d;
         ready_q  <= ready_d;
      end
   end

   // Storage arrays carry no reset; writes are suppressed while reset is asserted
   always_ff @(posedge clk) begin
      if (!reset && mem_we) mem[mem_waddr] <= mem_wentry;
      if (mem_re) ram_q <= mem[mem_raddr];
      if (!reset && fs_we) begin
         fs_base[push_idx] <= base_q;
         fs_size[push_idx] <= size_q;
      end
   end

   assign op_ready    = ready_q;
   assign rdata       = rdata_q;
   assign rtype       = rtype_q;
   assign rvalid      = rvalid_q;
   assign frame_level = level_q;
   assign trap        = trap_q;

endmodule

// File: tb/tb_locals_frame_unit.sv
// Bench for locals_frame_unit: two instances (64-bit/deep and 32-bit/shallow), table plus directed sequences.
module tb_locals_frame_unit;

   localparam logic [2:0] GET = 3'd0, SET = 3'd1, TEE = 3'd2, PUSH = 3'd3, POP = 3'd4;
   localparam logic [1:0] I32 = 2'd0, I64 = 2'd1, F32 = 2'd2, F64 = 2'd3;
   localparam logic [3:0] T_NONE = 4'd0, T_BAD_OP = 4'd1, T_NO_64B = 4'd2, T_BAD_INDEX = 4'd3,
                          T_OVF = 4'd4, T_UNF = 4'd5;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        op_valid_a = 1'b0, op_valid_b = 1'b0;
   logic [2:0]  op = '0;
   logic [5:0]  index = '0;
   logic [6:0]  frame_size = '0;
   logic [63:0] wdata = '0;
   logic [1:0]  wtype = '0;

   logic        op_ready_a, rvalid_a, op_ready_b, rvalid_b;
   logic [63:0] rdata_a, rdata_b;
   logic [1:0]  rtype_a, rtype_b;
   logic [3:0]  frame_level_a, trap_a, trap_b;
   logic [1:0]  frame_level_b;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   typedef struct {
      logic [63:0] d;
      logic [1:0]  t;
      int          c;
   } exp_rec_t;
   exp_rec_t q_a[$];
   exp_rec_t q_b[$];

   typedef struct {
      logic [2:0]  op;
      logic [5:0]  idx;
      logic [6:0]  fs;
      logic [63:0] wd;
      logic [1:0]  wt;
      bit          rv;
      logic [63:0] ed;
      logic [1:0]  et;
   } vec_t;
   vec_t tbl[14];

   locals_frame_unit #(.USE_64B(1'b1), .LOCAL_AW(6), .FRAME_AW(3)) dut_a (
      .clk(clk), .reset(reset), .op_valid(op_valid_a), .op_ready(op_ready_a), .op(op),
      .index(index), .frame_size(frame_size), .wdata(wdata), .wtype(wtype),
      .rdata(rdata_a), .rtype(rtype_a), .rvalid(rvalid_a), .frame_level(frame_level_a), .trap(trap_a)
   );

   locals_frame_unit #(.USE_64B(1'b0), .LOCAL_AW(4), .FRAME_AW(1)) dut_b (
      .clk(clk), .reset(reset), .op_valid(op_valid_b), .op_ready(op_ready_b), .op(op),
      .index(index[3:0]), .frame_size(frame_size[4:0]), .wdata(wdata), .wtype(wtype),
      .rdata(rdata_b), .rtype(rtype_b), .rvalid(rvalid_b), .frame_level(frame_level_b), .trap(trap_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every rvalid pulse must match the oldest expected result, including its cycle
   always @(negedge clk) begin
      exp_rec_t e;
      if (rvalid_a === 1'b1) begin
         if (q_a.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_rvalid_a: got rvalid 1 expected 0 at cycle %0d", cyc);
         end else begin
            e = q_a.pop_front();
            check("rdata_a", rdata_a, e.d);
            check("rtype_a", 64'(rtype_a), 64'(e.t));
            check("rvalid_cycle_a", 64'(cyc), 64'(e.c));
         end
      end
      if (rvalid_b === 1'b1) begin
         if (q_b.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_rvalid_b: got rvalid 1 expected 0 at cycle %0d", cyc);
         end else begin
            e = q_b.pop_front();
            check("rdata_b", rdata_b, e.d);
            check("rtype_b", 64'(rtype_b), 64'(e.t));
            check("rvalid_cycle_b", 64'(cyc), 64'(e.c));
         end
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sync();
      reset = 1'b0;
   endtask

   // Issue one op (called at posedge+1); returns at posedge+1 just after the accept edge
   task automatic do_op(input int sel, input logic [2:0] o, input logic [5:0] idx,
                        input logic [6:0] fs, input logic [63:0] wd, input logic [1:0] wt,
                        input bit rv, input logic [63:0] ed, input logic [1:0] et);
      int k;
      exp_rec_t e;
      k = 0;
      while (((sel == 0) ? op_ready_a : op_ready_b) !== 1'b1 && k < 100) begin
         sync();
         k++;
      end
      if (k == 100) begin
         n_cmp++; n_err++;
         $display("FAIL ready_timeout: got op_ready 0 expected 1 (sel %0d)", sel);
      end
      op = o; index = idx; frame_size = fs; wdata = wd; wtype = wt;
      if (sel == 0) op_valid_a = 1'b1; else op_valid_b = 1'b1;
      @(posedge clk);
      #1;
      op_valid_a = 1'b0;
      op_valid_b = 1'b0;
      if (rv) begin
         e.d = ed; e.t = et; e.c = (o == GET) ? cyc + 1 : cyc;
         if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] o, input logic [5:0] idx, input logic [6:0] fs,
                               input logic [63:0] wd, input logic [1:0] wt, input bit rv,
                               input logic [63:0] ed, input logic [1:0] et);
      vec_t v;
      v.op = o; v.idx = idx; v.fs = fs; v.wd = wd; v.wt = wt; v.rv = rv; v.ed = ed; v.et = et;
      return v;
   endfunction

   task automatic expect_halt(input int sel, input logic [3:0] code, input string name);
      check({name, "_trap"}, 64'((sel == 0) ? trap_a : trap_b), 64'(code));
      check({name, "_ready"}, 64'((sel == 0) ? op_ready_a : op_ready_b), 64'(0));
      repeat (3) sync();
      check({name, "_ready_held"}, 64'((sel == 0) ? op_ready_a : op_ready_b), 64'(0));
      do_reset();
      check({name, "_ready_after_reset"}, 64'((sel == 0) ? op_ready_a : op_ready_b), 64'(1));
   endtask

   initial begin
      tbl[0]  = mk(PUSH, 6'd0, 7'd2, 64'd0, I32, 1'b0, 64'd0, I32);
      tbl[1]  = mk(SET,  6'd1, 7'd0, 64'd3, I64, 1'b0, 64'd0, I32);
      tbl[2]  = mk(GET,  6'd1, 7'd0, 64'd0, I32, 1'b1, 64'd3, I64);
      tbl[3]  = mk(TEE,  6'd0, 7'd0, 64'hAB, F32, 1'b1, 64'hAB, F32);
      tbl[4]  = mk(GET,  6'd0, 7'd0, 64'd0, I32, 1'b1, 64'hAB, F32);
      tbl[5]  = mk(PUSH, 6'd0, 7'd4, 64'd0, I32, 1'b0, 64'd0, I32);
      tbl[6]  = mk(GET,  6'd3, 7'd0, 64'd0, I32, 1'b1, 64'd0, I32);
      tbl[7]  = mk(SET,  6'd2, 7'd0, 64'h4000_0000_0000_0001, F64, 1'b0, 64'd0, I32);
      tbl[8]  = mk(GET,  6'd2, 7'd0, 64'd0, I32, 1'b1, 64'h4000_0000_0000_0001, F64);
      tbl[9]  = mk(POP,  6'd0, 7'd0, 64'd0, I32, 1'b0, 64'd0, I32);
      tbl[10] = mk(GET,  6'd1, 7'd0, 64'd0, I32, 1'b1, 64'd3, I64);
      tbl[11] = mk(PUSH, 6'd0, 7'd3, 64'd0, I32, 1'b0, 64'd0, I32);
      tbl[12] = mk(GET,  6'd2, 7'd0, 64'd0, I32, 1'b1, 64'd0, I32);
      tbl[13] = mk(POP,  6'd0, 7'd0, 64'd0, I32, 1'b0, 64'd0, I32);

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_ready_a", 64'(op_ready_a), 64'(1));
      check("rst_rvalid_a", 64'(rvalid_a), 64'(0));
      check("rst_rdata_a", rdata_a, 64'(0));
      check("rst_rtype_a", 64'(rtype_a), 64'(I32));
      check("rst_level_a", 64'(frame_level_a), 64'(0));
      check("rst_trap_a", 64'(trap_a), 64'(T_NONE));
      check("rst_ready_b", 64'(op_ready_b), 64'(1));
      check("rst_level_b", 64'(frame_level_b), 64'(0));

      for (int i = 0; i < 14; i++)
         do_op(0, tbl[i].op, tbl[i].idx, tbl[i].fs, tbl[i].wd, tbl[i].wt, tbl[i].rv, tbl[i].ed, tbl[i].et);
      repeat (3) sync();
      check("tbl_level_a", 64'(frame_level_a), 64'(1));
      check("tbl_trap_a", 64'(trap_a), 64'(T_NONE));

      // Nested frames each see their own zeroed window
      do_reset();
      do_op(0, PUSH, 6'd0, 7'd2, 64'd0, I32, 1'b0, 64'd0, I32);
      do_op(0, SET, 6'd0, 7'd0, 64'd7, I32, 1'b0, 64'd0, I32);
      do_op(0, PUSH, 6'd0, 7'd3, 64'd0, I32, 1'b0, 64'd0, I32);
      check("nest_level2", 64'(frame_level_a), 64'(2));
      do_op(0, GET, 6'd0, 7'd0, 64'd0, I32, 1'b1, 64'd0, I32);
      do_op(0, POP, 6'd0, 7'd0, 64'd0, I32, 1'b0, 64'd0, I32);
      do_op(0, GET, 6'd0, 7'd0, 64'd0, I32, 1'b1, 64'd7, I32);
      sync();
      check("nest_level1", 64'(frame_level_a), 64'(1));

      // Zero-fill of 4 locals holds op_ready low for exactly 4 cycles
      do_op(0, PUSH, 6'd0, 7'd4, 64'd0, I32, 1'b0, 64'd0, I32);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("fill_ready_low", 64'(op_ready_a), 64'(0));
      end
      @(negedge clk);
      check("fill_ready_high", 64'(op_ready_a), 64'(1));
      sync();
      do_op(0, GET, 6'd3, 7'd0, 64'd0, I32, 1'b1, 64'd0, I32);
      repeat (3) sync();

      // Traps on the 64-bit instance
      do_reset();
      do_op(0, GET, 6'd0, 7'd0, 64'd0, I32, 1'b0, 64'd0, I32);
      expect_halt(0, T_BAD_INDEX, "get_level0");
      do_op(0, POP, 6'd0, 7'd0, 64'd0, I32, 1'b0, 64'd0, I32);
      expect_halt(0, T_UNF, "pop_level0");
      do_op(0, 3'd5, 6'd10, 7'd0, 64'd0, I64, 1'b0, 64'd0, I32);
      expect_halt(0, T_BAD_OP, "bad_op");

      // 32-bit-only instance: upper half of stored data is dropped, 64-bit types trap
      do_op(1, PUSH, 6'd0, 7'd2, 64'd0, I32, 1'b0, 64'd0, I32);
      do_op(1, SET, 6'd0, 7'd0, 64'hFFFF_FFFF_1234_5678, I32, 1'b0, 64'd0, I32);
      do_op(1, GET, 6'd0, 7'd0, 64'd0, I32, 1'b1, 64'h0000_0000_1234_5678, I32);
      do_op(1, TEE, 6'd1, 7'd0, 64'd9, I64, 1'b0, 64'd0, I32);
      check("no64_level", 64'(frame_level_b), 64'(1));
      expect_halt(1, T_NO_64B, "tee_i64");
      do_op(1, TEE, 6'd5, 7'd0, 64'd9, F64, 1'b0, 64'd0, I32);
      expect_halt(1, T_NO_64B, "no64_over_index");

      // Frame-stack depth 2 and a 16-entry RAM
      do_op(1, PUSH, 6'd0, 7'd1, 64'd0, I32, 1'b0, 64'd0, I32);
      do_op(1, PUSH, 6'd0, 7'd1, 64'd0, I32, 1'b0, 64'd0, I32);
      sync();
      check("depth_level2", 64'(frame_level_b), 64'(2));
      do_op(1, PUSH, 6'd0, 7'd1, 64'd0, I32, 1'b0, 64'd0, I32);
      expect_halt(1, T_OVF, "third_push");
      do_op(1, PUSH, 6'd0, 7'd16, 64'd0, I32, 1'b0, 64'd0, I32);
      do_op(1, GET, 6'd15, 7'd0, 64'd0, I32, 1'b1, 64'd0, I32);
      sync();
      check("full_ram_trap", 64'(trap_b), 64'(T_NONE));
      check("full_ram_level", 64'(frame_level_b), 64'(1));
      do_reset();
      do_op(1, PUSH, 6'd0, 7'd8, 64'd0, I32, 1'b0, 64'd0, I32);
      do_op(1, PUSH, 6'd0, 7'd9, 64'd0, I32, 1'b0, 64'd0, I32);
      expect_halt(1, T_OVF, "ram_overflow");

      // Reset in the middle of a zero-fill
      do_op(1, PUSH, 6'd0, 7'd10, 64'd0, I32, 1'b0, 64'd0, I32);
      sync();
      sync();
      check("init_ready_low", 64'(op_ready_b), 64'(0));
      do_reset();
      check("init_rst_level", 64'(frame_level_b), 64'(0));
      check("init_rst_ready", 64'(op_ready_b), 64'(1));
      check("init_rst_trap", 64'(trap_b), 64'(T_NONE));

      repeat (5) sync();
      check("sb_a_empty", 64'(q_a.size()), 64'(0));
      check("sb_b_empty", 64'(q_b.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
